serial_deframer: RTL and testbench
==================================

SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameter N, default 7, word width minus one; the data word is N+1 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-004 in  input  1  serial line, idles high, LSB-first frames; sampled at every posedge clk.
REQ-005 ready  input  1  consumer accepts out when ready=1 and valid=1 at the same posedge.
REQ-006 out  output  N+1  last accepted data word, held stable while valid=1.
REQ-007 valid  output  1  out holds an unconsumed word.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 parity_err  output  1  one-cycle pulse when a frame is dropped for bad parity.
REQ-010 frame_err  output  1  one-cycle pulse when a frame is dropped for a bad stop bit.
REQ-011 overrun  output  1  one-cycle pulse when a good frame is dropped because the holding register is full.

Function
REQ-012 The frame format SHALL be: start(0), N+1 data bits with in[0] first, even parity bit, stop(1); N+4 clk cycles per frame, one bit per cycle.
REQ-013 The FSM SHALL use states IDLE, DATA, PARITY and STOP; IDLE is the reset state.
REQ-014 In IDLE: in=0 -> DATA with the bit counter cleared; in=1 -> stay in IDLE.
REQ-015 In DATA: the sampled bit SHALL be stored at shift-register position count, and count increments; after bit N is sampled -> PARITY.
REQ-016 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap inside a frame.
REQ-017 In PARITY: in is latched as the parity bit -> STOP.
REQ-018 In STOP: the block always returns to IDLE on the next edge.
REQ-019 In STOP, the first matching rule decides the result:
- in=0 -> frame_err=1;
- else XOR of data bits and parity bit is 1 -> parity_err=1;
- else the frame is good.
REQ-020 A good frame SHALL load out and set valid=1 at the same edge that samples the stop bit, provided valid=0 or ready=1 at that edge.
REQ-021 A good frame arriving while valid=1 and ready=0 SHALL be dropped, with out unchanged and overrun=1.
REQ-022 valid SHALL clear on a ready&valid edge unless a good frame loads at the same edge, in which case valid stays 1 and out takes the new word.
REQ-023 Only one of parity_err, frame_err and overrun SHALL be asserted in any cycle; each is registered and high for exactly one cycle.
REQ-024 A start bit SHALL be accepted on the cycle immediately after STOP, so back-to-back frames lose no cycles.
REQ-025 ready SHALL have no effect on the FSM; reception continues regardless of the consumer.

Reset
REQ-026 reset=0 SHALL force state=IDLE, count=0, shift register=0, out=0, valid=0, busy=0 and all error pulses=0 asynchronously.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame; after release, the block waits for a new start bit.
REQ-028 The first posedge with reset=1 SHALL already sample in as in IDLE.

Verification (N=7)
REQ-029 Send 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) with ready=0 -> out=0xA5 and valid=1 at the stop edge, with no error pulses.
REQ-030 Send 0x01 with parity bit 0 -> parity_err pulses once, valid stays 0 and out is unchanged.
REQ-031 Send 0x3C with stop bit 0 -> frame_err pulses once, valid=0, and the FSM returns to IDLE.
REQ-032 With ready=0, send 0x11 then 0x22 -> overrun pulses on the second stop edge and out stays 0x11; raising ready at the second stop edge instead -> out=0x22 and valid stays 1.
REQ-033 Send 0xFF, then 0x00 starting the next cycle with ready=1 -> both words are delivered 11 cycles apart with valid=1 for one cycle each.
REQ-034 Assert reset after the 4th data bit of a frame, then send 0x5A -> out=0x5A, with no stale bits and no error pulses.

Source files
------------

// File: rtl/serial_deframer_if.sv
`default_nettype none
// serial_deframer_if: serial line and consumer handshake into the deframer,
// received word and one-cycle error pulses out of it.
interface serial_deframer_if #(
  parameter int N = 7
);
  logic       in;
  logic       ready;
  logic [N:0] out;
  logic       valid;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output in, ready,
    input  out, valid, busy, parity_err, frame_err, overrun
  );

  modport slave (
    input  in, ready,
    output out, valid, busy, parity_err, frame_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/serial_deframer.sv
`default_nettype none
// serial_deframer: LSB-first start/data/even-parity/stop receiver with a
// one-word holding register and registered one-cycle error pulses.
module serial_deframer #(
  parameter int N = 7
) (
  input wire               clk,
  input wire               reset,
  serial_deframer_if.slave bus
);

  localparam int CW = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [N:0]    shift_q;
  logic          parity_q;
  logic [N:0]    out_q;
  logic          valid_q;
  logic          busy_q;
  logic          perr_q;
  logic          ferr_q;
  logic          ovr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      // A load at the stop edge below overrides this consume-clear.
      if (valid_q && bus.ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!bus.in) begin
            state_q <= DATA;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        DATA: begin
          shift_q[count_q] <= bus.in;
          if (count_q == LAST) state_q <= PARITY;
          else                 count_q <= count_q + 1'b1;
        end
        PARITY: begin
          parity_q <= bus.in;
          state_q  <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!bus.in)                     ferr_q <= 1'b1;
          else if (^{shift_q, parity_q})   perr_q <= 1'b1;
          else if (valid_q && !bus.ready)  ovr_q  <= 1'b1;
          else begin
            out_q   <= shift_q;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out        = out_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_deframer.sv
`default_nettype none
// tb_serial_deframer: directed and random frames checked against a
// frame-level model of the receiver's outcome and holding register.
module tb_serial_deframer;

  localparam int N = 7;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [N:0] m_out   = '0;
  logic       m_valid = 1'b0;

  serial_deframer_if #(.N(N)) bus ();

  serial_deframer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic ebusy, input logic eperr, input logic eferr,
                           input logic eovr);
    chk("out",        32'(bus.out),   32'(m_out));
    chk("valid",      32'(bus.valid), 32'(m_valid));
    chk("busy",       32'(bus.busy),  32'(ebusy));
    chk("parity_err", 32'(bus.parity_err), 32'(eperr));
    chk("frame_err",  32'(bus.frame_err),  32'(eferr));
    chk("overrun",    32'(bus.overrun),    32'(eovr));
  endtask

  // One bit period: drive, clock, apply frame-level rules, then check.
  task automatic tick(input logic in_v, input logic rdy_v, input logic ebusy,
                      input logic is_stop, input logic [N:0] d, input logic p);
    logic eperr, eferr, eovr, load;
    @(negedge clk);
    bus.in    = in_v;
    bus.ready = rdy_v;
    @(posedge clk);
    eperr = 1'b0; eferr = 1'b0; eovr = 1'b0; load = 1'b0;
    if (is_stop) begin
      if (!in_v)                     eferr = 1'b1;
      else if ((^d) != p)            eperr = 1'b1;
      else if (m_valid && !rdy_v)    eovr  = 1'b1;
      else                           load  = 1'b1;
    end
    if (load) begin
      m_out   = d;
      m_valid = 1'b1;
    end else if (m_valid && rdy_v) begin
      m_valid = 1'b0;
    end
    #1;
    check_all(ebusy, eperr, eferr, eovr);
  endtask

  function automatic logic pick_ready(input int rmode, input logic at_stop);
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return logic'($urandom_range(0, 1));
      default: return at_stop;
    endcase
  endfunction

  task automatic idle(input logic rdy_v);
    tick(1'b1, rdy_v, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_frame(input logic [N:0] d, input logic p, input logic s, input int rmode);
    tick(1'b0, pick_ready(rmode, 1'b0), 1'b1, 1'b0, d, p);
    for (int i = 0; i <= N; i++) tick(d[i], pick_ready(rmode, 1'b0), 1'b1, 1'b0, d, p);
    tick(p, pick_ready(rmode, 1'b0), 1'b1, 1'b0, d, p);
    tick(s, pick_ready(rmode, 1'b1), 1'b0, 1'b1, d, p);
  endtask

  initial begin
    logic [N:0] d;
    logic       p, s;

    reset     = 1'b0;
    bus.in    = 1'b1;
    bus.ready = 1'b0;
    #1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    // Good word with no consumer, then consume it.
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(1'b1);
    idle(1'b0);

    // Bad parity, then bad stop bit.
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    idle(1'b0);

    // Overrun with holding register full, then ready raised at the stop edge.
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    idle(1'b1);
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 3);
    idle(1'b1);

    // Back-to-back frames with a permanently ready consumer.
    send_frame(8'hFF, 1'b0, 1'b1, 1);
    send_frame(8'h00, 1'b0, 1'b1, 1);
    idle(1'b1);

    // Reset after the 4th data bit, then a fresh frame right after release.
    d = 8'hF0;
    tick(1'b0, 1'b1, 1'b1, 1'b0, d, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, d, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    bus.in    = 1'b1;
    bus.ready = 1'b0;
    #1;
    m_out   = '0;
    m_valid = 1'b0;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    idle(1'b1);

    // Random frames: mostly good, random consumer, random gaps.
    for (int f = 0; f < 40; f++) begin
      d = N'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 5) != 0);
      send_frame(d, p, s, 2);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle(logic'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
